// File: rtl/dpll_lock_supervisor.sv
// Supervises a word-clock DPLL: pulses its reset, qualifies lock over ACQ_WORDS good words, drops to HOLD on misses or timeout.
// Optional macro LOCK_STATS_EN adds err_count (bad words seen in TRACK).
`timescale 1ns/1ps

module dpll_lock_supervisor #(
    parameter int HOLD_CYCLES   = 16,
    parameter int ACQ_WORDS     = 4,
    parameter int MAX_MISS      = 2,
    parameter int BITS_PER_WORD = 256,
    parameter int TMO_W         = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wc,
    input  logic        bitclock,
    input  logic        locked,
    output logic        dpll_rstn,
    output logic        ready,
    output logic [7:0]  slot,
    output logic [1:0]  state
`ifdef LOCK_STATS_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GOOD_W = $clog2(ACQ_WORDS + 1);
    localparam int MISS_W = $clog2(MAX_MISS + 1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2
    } state_e;

    state_e             state_q;
    logic               wc_q, bc_q;
    logic               dpll_rstn_q, ready_q, armed_q;
    logic [8:0]         bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [GOOD_W-1:0]  good_cnt_q;
    logic [MISS_W-1:0]  miss_cnt_q;
    logic               wc_rise, bc_rise, word_good, timeout, enter_hold;

    assign wc_rise   = wc & ~wc_q;
    assign bc_rise   = bitclock & ~bc_q;
    assign word_good = (bit_cnt_q == 9'(BITS_PER_WORD)) && locked;
    assign timeout   = &tmo_q;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (wc_rise)
            bit_cnt_d = {8'd0, bc_rise};
        else if (bc_rise && bit_cnt_q != 9'd511)
            bit_cnt_d = bit_cnt_q + 9'd1;
        tmo_d = wc_rise ? '0 : tmo_q + TMO_W'(1);
    end

    // Timeout outranks a coincident judged word; it is ignored while already in HOLD.
    always_comb begin
        enter_hold = 1'b0;
        case (state_q)
            ST_HOLD:  enter_hold = 1'b0;
            ST_ACQ:   enter_hold = timeout;
            ST_TRACK: enter_hold = timeout ||
                                   (wc_rise && !word_good && miss_cnt_q == MISS_W'(MAX_MISS - 1));
            default:  enter_hold = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_HOLD;
            wc_q        <= 1'b0;
            bc_q        <= 1'b0;
            dpll_rstn_q <= 1'b0;
            ready_q     <= 1'b0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            hold_cnt_q  <= '0;
            good_cnt_q  <= '0;
            miss_cnt_q  <= '0;
        end else begin
            wc_q      <= wc;
            bc_q      <= bitclock;
            bit_cnt_q <= bit_cnt_d;
            tmo_q     <= tmo_d;
            ready_q   <= (state_q == ST_TRACK);
            if (enter_hold) begin
                state_q     <= ST_HOLD;
                dpll_rstn_q <= 1'b0;
                hold_cnt_q  <= '0;
                tmo_q       <= '0;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                            state_q     <= ST_ACQ;
                            dpll_rstn_q <= 1'b1;
                            good_cnt_q  <= '0;
                            armed_q     <= 1'b0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                        end
                    end
                    ST_ACQ: begin
                        // First edge after release only starts a clean bit count.
                        if (wc_rise) begin
                            if (!armed_q) begin
                                armed_q <= 1'b1;
                            end else if (!word_good) begin
                                good_cnt_q <= '0;
                            end else if (good_cnt_q == GOOD_W'(ACQ_WORDS - 1)) begin
                                state_q    <= ST_TRACK;
                                miss_cnt_q <= '0;
                            end else begin
                                good_cnt_q <= good_cnt_q + GOOD_W'(1);
                            end
                        end
                    end
                    ST_TRACK: begin
                        if (wc_rise) begin
                            if (word_good)
                                miss_cnt_q <= '0;
                            else
                                miss_cnt_q <= miss_cnt_q + MISS_W'(1);
                        end
                    end
                    default: state_q <= ST_HOLD;
                endcase
            end
        end
    end

`ifdef LOCK_STATS_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset)
            err_cnt_q <= '0;
        else if (state_q == ST_TRACK && wc_rise && !word_good && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign err_count = err_cnt_q;
`endif

    assign dpll_rstn = dpll_rstn_q;
    assign ready     = ready_q;
    assign slot      = bit_cnt_q[7:0];
    assign state     = state_q;

endmodule

// File: tb/tb_dpll_lock_supervisor.sv
// Directed bench: acquisition, short word, lock loss, timeout and mid-track reset on dpll_lock_supervisor.
`timescale 1ns/1ps

module tb_dpll_lock_supervisor;

    localparam int TMO_W_TB = 12;
    localparam int WORD_CYC = 2560;
    localparam int TMO_CYC  = 1 << TMO_W_TB;

    logic       clk = 1'b0;
    logic       reset, wc, bitclock, locked;
    logic       dpll_rstn, ready;
    logic [7:0] slot;
    logic [1:0] state;
`ifdef LOCK_STATS_EN
    logic [15:0] err_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic st_c0_ok;
    logic [1:0] st_c0, st_c16;
    logic [7:0] slot_c0;
    logic rdy_c0, rdy_c1, rstn_c0, rstn_c15, rstn_c16;

    dpll_lock_supervisor #(
        .HOLD_CYCLES  (16),
        .ACQ_WORDS    (4),
        .MAX_MISS     (2),
        .BITS_PER_WORD(256),
        .TMO_W        (TMO_W_TB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wc       (wc),
        .bitclock (bitclock),
        .locked   (locked),
        .dpll_rstn(dpll_rstn),
        .ready    (ready),
        .slot     (slot),
        .state    (state)
`ifdef LOCK_STATS_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one clk cycle of inputs; outputs are read 1ns after the edge that sampled them.
    task automatic step(input logic wc_v, input logic bc_v);
        wc       = wc_v;
        bitclock = bc_v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // One word period: wc high for the first half, nbits bitclock pulses of period 10 starting at cycle off.
    task automatic run_word(input int nbits, input int off, input logic lk);
        locked = lk;
        for (int c = 0; c < WORD_CYC; c++) begin
            int cc;
            cc = c - off;
            step(c < WORD_CYC / 2, (cc >= 0) && (cc % 10 < 5) && (cc / 10 < nbits));
            if (c == 0) begin
                st_c0   = state;
                rdy_c0  = ready;
                slot_c0 = slot;
                rstn_c0 = dpll_rstn;
            end
            if (c == 1)  rdy_c1   = ready;
            if (c == 15) rstn_c15 = dpll_rstn;
            if (c == 16) begin
                rstn_c16 = dpll_rstn;
                st_c16   = state;
            end
        end
    endtask

    initial begin
        reset = 1'b0; wc = 1'b0; bitclock = 1'b0; locked = 1'b1;
        st_c0_ok = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        check_val("rst_state", state, 0);
        check_val("rst_rstn", dpll_rstn, 0);
        check_val("rst_ready", ready, 0);
        check_val("rst_slot", slot, 0);
`ifdef LOCK_STATS_EN
        check_val("rst_err", err_count, 0);
`endif

        reset = 1'b1;
        idle(15);
        check_val("hold15_rstn", dpll_rstn, 0);
        check_val("hold15_state", state, 0);
        idle(1);
        check_val("hold16_rstn", dpll_rstn, 1);
        check_val("hold16_state", state, 1);

        run_word(256, 0, 1'b1);
        check_val("acq_w1_state", st_c0, 1);
        check_val("acq_w1_slot", slot_c0, 1);
        run_word(256, 0, 1'b1);
        run_word(256, 3, 1'b1);
        check_val("acq_w3_slot_nocoinc", slot_c0, 0);
        run_word(256, 0, 1'b1);
        check_val("acq_w4_state", st_c0, 1);
        check_val("acq_w4_slot", slot_c0, 1);
        run_word(256, 0, 1'b1);
        check_val("lock_state", st_c0, 2);
        check_val("lock_rdy_c0", rdy_c0, 0);
        check_val("lock_rdy_c1", rdy_c1, 1);
        check_val("lock_rstn", rstn_c0, 1);
        check_val("lock_slot", slot_c0, 1);

        run_word(255, 0, 1'b1);
        run_word(256, 0, 1'b1);
        check_val("short_state", st_c0, 2);
        check_val("short_ready", rdy_c1, 1);
`ifdef LOCK_STATS_EN
        check_val("short_err", err_count, 1);
`endif
        run_word(256, 0, 1'b1);
        run_word(256, 0, 1'b0);
        check_val("miss_cleared_state", st_c0, 2);
        run_word(256, 0, 1'b0);
        check_val("loss_state", st_c0, 0);
        check_val("loss_rstn_c0", rstn_c0, 0);
        check_val("loss_rdy_c1", rdy_c1, 0);
        check_val("loss_rstn_c15", rstn_c15, 0);
        check_val("loss_rstn_c16", rstn_c16, 1);
        check_val("loss_state_c16", st_c16, 1);
`ifdef LOCK_STATS_EN
        check_val("loss_err", err_count, 3);
`endif

        run_word(256, 0, 1'b1);
        check_val("reacq_w1_state", st_c0, 1);
        repeat (3) run_word(256, 0, 1'b1);
        run_word(256, 0, 1'b1);
        check_val("reacq_state", st_c0, 2);
        check_val("reacq_rdy_c1", rdy_c1, 1);

        idle(TMO_CYC - WORD_CYC);
        check_val("tmo_pre_state", state, 2);
        idle(1);
        check_val("tmo_state", state, 0);
        check_val("tmo_rstn", dpll_rstn, 0);
        idle(1);
        check_val("tmo_ready", ready, 0);

        idle(20);
        repeat (4) run_word(256, 0, 1'b1);
        run_word(256, 0, 1'b1);
        check_val("reacq2_state", st_c0, 2);

        locked = 1'b1;
        for (int c = 0; c < 100; c++) step(1'b1, (c % 10) < 5);
        check_val("pre_rst_ready", ready, 1);
        check_val("pre_rst_slot", slot, 10);
        reset = 1'b0;
        step(1'b1, 1'b0);
        check_val("mid_rst_state", state, 0);
        check_val("mid_rst_ready", ready, 0);
        check_val("mid_rst_rstn", dpll_rstn, 0);
        check_val("mid_rst_slot", slot, 0);
`ifdef LOCK_STATS_EN
        check_val("mid_rst_err", err_count, 0);
`endif
        reset = 1'b1;
        idle(15);
        check_val("rehold15_rstn", dpll_rstn, 0);
        idle(1);
        check_val("rehold16_rstn", dpll_rstn, 1);
        check_val("rehold16_state", state, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dpll_lock_supervisor.md
DPLL_LOCK_SUPERVISOR -- requirements
Module: dpll_lock_supervisor

Interface
REQ-001 Parameter HOLD_CYCLES, 16, number of clk cycles dpll_rstn is held low per reset pulse.
REQ-002 Parameter ACQ_WORDS, 4, consecutive good words required to declare ready.
REQ-003 Parameter MAX_MISS, 2, consecutive bad words in TRACK that force re-acquisition.
REQ-004 Parameter BITS_PER_WORD, 256, expected bitclock rising edges per word period.
REQ-005 Parameter TMO_W, 20, width of the word-clock timeout counter.
REQ-006 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-007 reset  input  1  reset, synchronous, active-low.
REQ-008 wc  input  1  word clock, the same signal fed to the dpll.
REQ-009 bitclock  input  1  recovered bit clock from the dpll.
REQ-010 locked  input  1  dpll lock flag.
REQ-011 dpll_rstn  output  1  active-low synchronous reset driven to the dpll.
REQ-012 ready  output  1  high while in TRACK; bit stream usable.
REQ-013 slot  output  8  bit index within current word (low 8 bits of bit counter).
REQ-014 state  output  2  FSM state: 0 HOLD, 1 ACQUIRE, 2 TRACK.
REQ-015 err_count  output  16  bad words seen in TRACK (present only with LOCK_STATS_EN).

Function
REQ-016 The block SHALL register wc and bitclock once and form wc_rise = wc & ~wc_q and bc_rise = bitclock & ~bc_q.
REQ-017 The 9-bit bit counter SHALL clear to 0 on wc_rise, load 1 when wc_rise and bc_rise coincide, else increment on bc_rise, saturating at 511.
REQ-018 On wc_rise a word SHALL be good iff the pre-update bit counter equals BITS_PER_WORD and locked is 1; otherwise bad.
REQ-019 The timeout counter SHALL clear on wc_rise, increment otherwise, and assert timeout when all ones.
REQ-020 HOLD: dpll_rstn=0, hold counter counts HOLD_CYCLES cycles, then go to ACQUIRE with good counter cleared.
REQ-021 ACQUIRE: good word increments good counter, bad word clears it; reaching ACQ_WORDS goes to TRACK with miss counter cleared.
REQ-022 TRACK: good word clears miss counter, bad word increments it; reaching MAX_MISS goes to HOLD.
REQ-023 Timeout in ACQUIRE or TRACK SHALL go to HOLD next cycle; timeout is ignored in HOLD and the timeout counter is cleared on HOLD entry.
REQ-024 ready SHALL equal (state==TRACK) registered, asserting the cycle after the transition; latency from the ACQ_WORDS-th good wc_rise to ready is 2 clk cycles.
REQ-025 dpll_rstn SHALL be 1 in ACQUIRE and TRACK and 0 in HOLD; the first wc_rise of ACQUIRE only restarts counting and is never judged.
REQ-026 If timeout and a judged wc_rise coincide, timeout SHALL take priority.

Reset
REQ-027 When reset=0 at a clk edge: state=HOLD, dpll_rstn=0, ready=0, slot=0, all counters 0, wc_q=bc_q=0, err_count=0.
REQ-028 Reset asserted mid-TRACK SHALL drop ready on the next edge and restart the full HOLD sequence.

Configuration
REQ-029 With macro LOCK_STATS_EN defined, err_count SHALL increment (saturating at 65535) on each bad word in TRACK and clear only on reset.
REQ-030 Without LOCK_STATS_EN the err_count port and its counter SHALL not exist; all other behaviour is identical.

Verification
REQ-031 Reset released, wc period 2560 clk, bitclock every 10 clk, locked=1 -> dpll_rstn high after 16 cycles, ready=1 two cycles after 5th wc_rise.
REQ-032 In TRACK, one word with 255 bitclocks -> ready stays 1, err_count=1; next word 256 -> miss counter 0.
REQ-033 In TRACK, two consecutive words with locked=0 at wc_rise -> state=HOLD, ready=0, dpll_rstn=0 for 16 cycles.
REQ-034 wc held low for 2^20 cycles in TRACK -> state=HOLD on timeout cycle +1.
REQ-035 wc_rise and bc_rise in same cycle -> slot=1 next cycle; word counted as good with 256 edges.
REQ-036 reset pulsed low for one cycle mid-TRACK -> all outputs at reset values next edge, HOLD sequence repeats.
